// File: rtl/muldiv_stall_controller.sv
// muldiv_stall_controller: sequences the multi-cycle HI/LO mult/div unit and raises pipeline stalls
// Build option: define MULDIV_PERF_EN to build the saturating Stall_Count counter (otherwise tied to 0).
// Ports: Clk/Rst_n (async active-low); Start_EX, IsDiv_EX, DivByZero_EX issue from EX;
//   ReadHiLo_ID, MulDivOp_ID consumers waiting in ID; Abort squashes the in-flight op;
//   Unit_Start, HiLo_Write pulses; DivZero_Flag sticky; Busy; PCWrite, IF_ID_Write, FlushControl stalls;
//   Stall_Count stall-cycle counter.
module muldiv_stall_controller #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start_EX,
  input  logic        IsDiv_EX,
  input  logic        DivByZero_EX,
  input  logic        ReadHiLo_ID,
  input  logic        MulDivOp_ID,
  input  logic        Abort,
  output logic        Unit_Start,
  output logic        HiLo_Write,
  output logic        DivZero_Flag,
  output logic        Busy,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        FlushControl,
  output logic [15:0] Stall_Count
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic dz_q, dz_d;
  logic stall;
  assign Busy = (state_q == MUL) || (state_q == DIV);
  assign HiLo_Write = (state_q == DONE);
  assign DivZero_Flag = dz_q;
  // gated by Rst_n so every output sits at its reset value while reset is held
  assign Unit_Start = Rst_n && Start_EX && !Abort && !Busy && !(IsDiv_EX && DivByZero_EX);
  assign stall = (Busy || Unit_Start) && (ReadHiLo_ID || MulDivOp_ID);
  assign PCWrite = !stall;
  assign IF_ID_Write = !stall;
  assign FlushControl = stall;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dz_d = dz_q;
    if (Busy) begin
      // a start while busy is ignored; abort beats the final count
      if (Abort) begin
        state_d = IDLE;
        cnt_d = '0;
      end else if (cnt_q == '0) state_d = DONE;
      else cnt_d = cnt_q - 1'b1;
    end else if (Start_EX && !Abort) begin
      if (!IsDiv_EX) begin
        state_d = MUL;
        cnt_d = CNT_W'(MUL_CYCLES - 1);
      end else if (!DivByZero_EX) begin
        state_d = DIV;
        cnt_d = CNT_W'(DIV_CYCLES - 1);
      end else begin
        state_d = DONE;
        dz_d = 1'b1;
      end
    end else state_d = IDLE;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dz_q <= dz_d;
    end
  end
`ifdef MULDIV_PERF_EN
  logic [15:0] sc_q;
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) sc_q <= '0;
    else if (stall && sc_q != 16'hFFFF) sc_q <= sc_q + 16'd1;
  end
  assign Stall_Count = sc_q;
`else
  assign Stall_Count = 16'h0000;
`endif
endmodule

// File: tb/tb_muldiv_stall_controller.sv
// tb_muldiv_stall_controller: table-driven checks of the mult/div sequencer and stall outputs
module tb_muldiv_stall_controller;
  logic Clk, Rst_n, Start_EX, IsDiv_EX, DivByZero_EX, ReadHiLo_ID, MulDivOp_ID, Abort;
  logic Unit_Start, HiLo_Write, DivZero_Flag, Busy, PCWrite, IF_ID_Write, FlushControl;
  logic [15:0] Stall_Count;
`ifdef MULDIV_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct {
    logic st, dv, dz, rd, md, ab;
    logic us, hw, bz, stl, dzf;
  } vec_t;
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_sc = '0;
  vec_t tbl[$];
  muldiv_stall_controller dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start_EX(Start_EX), .IsDiv_EX(IsDiv_EX),
    .DivByZero_EX(DivByZero_EX), .ReadHiLo_ID(ReadHiLo_ID), .MulDivOp_ID(MulDivOp_ID),
    .Abort(Abort), .Unit_Start(Unit_Start), .HiLo_Write(HiLo_Write),
    .DivZero_Flag(DivZero_Flag), .Busy(Busy), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .FlushControl(FlushControl), .Stall_Count(Stall_Count)
  );
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  function automatic vec_t mk(logic st, dv, dz, rd, md, ab, us, hw, bz, stl, dzf);
    mk = '{st, dv, dz, rd, md, ab, us, hw, bz, stl, dzf};
  endfunction
  task automatic chk(string n, logic [15:0] a, logic [15:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s t=%0t got %h want %h", n, $time, a, e);
    end
  endtask
  // inputs change just after a rising edge; outputs are compared on the falling edge
  task automatic apply(vec_t v, string tag);
    Start_EX = v.st;
    IsDiv_EX = v.dv;
    DivByZero_EX = v.dz;
    ReadHiLo_ID = v.rd;
    MulDivOp_ID = v.md;
    Abort = v.ab;
    @(negedge Clk);
    chk({tag, " Unit_Start"}, 16'(Unit_Start), 16'(v.us));
    chk({tag, " HiLo_Write"}, 16'(HiLo_Write), 16'(v.hw));
    chk({tag, " Busy"}, 16'(Busy), 16'(v.bz));
    chk({tag, " PCWrite"}, 16'(PCWrite), 16'(!v.stl));
    chk({tag, " IF_ID_Write"}, 16'(IF_ID_Write), 16'(!v.stl));
    chk({tag, " FlushControl"}, 16'(FlushControl), 16'(v.stl));
    chk({tag, " DivZero_Flag"}, 16'(DivZero_Flag), 16'(v.dzf));
    chk({tag, " Stall_Count"}, Stall_Count, exp_sc);
    if (PERF && v.stl && Rst_n && exp_sc != 16'hFFFF) exp_sc++;
    @(posedge Clk);
    #1;
  endtask
  initial begin
    // mult with mfhi waiting in ID
    tbl.push_back(mk(1,0,0,1,0,0, 1,0,0,1,0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,0,1,0,0, 0,0,1,1,0));
    tbl.push_back(mk(0,0,0,1,0,0, 0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0));
    // mult, abort at 2, new mult at 3, illegal start at 5 ignored
    tbl.push_back(mk(1,0,0,0,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,1,0,0));
    tbl.push_back(mk(1,1,0,0,1,0, 0,0,1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0));
    // abort coincident with cnt==0
    tbl.push_back(mk(1,0,0,0,0,0, 1,0,0,0,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,0,0,0, 0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0));
    // divide by zero, then abort (with a start) in DONE
    tbl.push_back(mk(1,1,1,1,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,1, 0,1,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,1));
    // mult, then divide by zero issued in DONE -> DONE again
    tbl.push_back(mk(1,0,0,0,0,0, 1,0,0,0,1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,0,0,0,0, 0,0,1,0,1));
    tbl.push_back(mk(1,1,1,0,0,0, 0,1,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,1,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,1));
    Rst_n = 1'b0;
    {Start_EX, IsDiv_EX, DivByZero_EX, ReadHiLo_ID, MulDivOp_ID, Abort} = '0;
    @(posedge Clk);
    #1;
    apply(mk(0,0,0,0,0,0, 0,0,0,0,0), "reset");
    apply(mk(1,0,0,1,0,0, 0,0,0,0,0), "reset start");
    Rst_n = 1'b1;
    apply(mk(0,0,0,0,0,0, 0,0,0,0,0), "idle");
    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));
    // divide by 7 with a second mult/div waiting in ID
    apply(mk(1,1,0,0,1,0, 1,0,0,1,1), "div c0");
    for (int i = 1; i <= 32; i++) apply(mk(0,0,0,0,1,0, 0,0,1,1,1), $sformatf("div c%0d", i));
    apply(mk(0,0,0,0,1,0, 0,1,0,0,1), "div c33");
    apply(mk(0,0,0,0,0,0, 0,0,0,0,1), "div c34");
    // reset asserted mid-divide
    apply(mk(1,1,0,0,0,0, 1,0,0,0,1), "rdiv c0");
    for (int i = 1; i <= 9; i++) apply(mk(0,0,0,0,0,0, 0,0,1,0,1), $sformatf("rdiv c%0d", i));
    Rst_n = 1'b0;
    exp_sc = '0;
    apply(mk(1,0,0,1,0,0, 0,0,0,0,0), "rdiv c10");
    apply(mk(1,0,0,1,0,0, 0,0,0,0,0), "rdiv c11");
    Rst_n = 1'b1;
    for (int i = 12; i <= 14; i++) apply(mk(0,0,0,0,0,0, 0,0,0,0,0), $sformatf("rdiv c%0d", i));
    apply(mk(1,0,0,1,0,0, 1,0,0,1,0), "post m0");
    for (int i = 1; i <= 4; i++) apply(mk(0,0,0,1,0,0, 0,0,1,1,0), $sformatf("post m%0d", i));
    apply(mk(0,0,0,1,0,0, 0,1,0,0,0), "post m5");
    apply(mk(0,0,0,0,0,0, 0,0,0,0,0), "post m6");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
